// File: rtl/icache_pkg.sv
// icache_pkg: shared types and width helpers for the instruction cache.
//   t_icache_state : refill FSM state encoding (IDLE, REFILL, DONE)
//   *_width()      : address-field widths derived from the cache geometry
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } t_icache_state;

  // Word-offset field width inside a line.
  function automatic int off_width(input int block_words);
    return $clog2(block_words);
  endfunction

  // Line-index field width.
  function automatic int idx_width(input int set_count);
    return $clog2(set_count);
  endfunction

  // Tag = whatever address bits remain above index, offset and byte bits.
  function automatic int tag_width(input int addr_width, input int set_count,
                                   input int block_words);
    return addr_width - $clog2(set_count) - $clog2(block_words) - 2;
  endfunction

endpackage

// File: rtl/instr_cache_if.sv
// instr_cache_if: refill bus between the instruction cache and the memory side.
//   o_mem_req   cache -> mem  refill request, high for the whole refill
//   o_mem_addr  cache -> mem  block-aligned refill address
//   i_mem_valid mem -> cache  one refill beat present this cycle
//   i_mem_data  mem -> cache  refill beat data, ascending word order
// Handshake: there is no ready; while o_mem_req is high the cache accepts
// every cycle in which i_mem_valid is high as exactly one beat, and the
// memory side may insert idle cycles (i_mem_valid low) between beats.
interface instr_cache_if #(
  parameter int ADDR_WIDTH = 64
);
  logic                  o_mem_req;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  i_mem_valid;
  logic [31:0]           i_mem_data;

  modport master (output o_mem_req, o_mem_addr, input i_mem_valid, i_mem_data);
  modport slave  (input o_mem_req, o_mem_addr, output i_mem_valid, i_mem_data);
endinterface

// File: rtl/icache_refill_ctr.sv
// icache_refill_ctr: refill beat counter with terminal-count flag.
//   clear : restart at 0 (wins over inc)
//   inc   : advance by one beat; wraps to 0 after the last word
//   count : current word position in the line
//   last  : count is at the final word of the line
module icache_refill_ctr #(
  parameter int BLOCK_WORDS = 16,
  parameter int CW          = $clog2(BLOCK_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)    count_d = '0;
    else if (inc) count_d = count_q + 1'b1;  // power-of-two size wraps for free
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign last  = (count_q == CW'(BLOCK_WORDS - 1));
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache with block refill.
//   clk, arst    clock, asynchronous active-high reset
//   i_start      fetch request (held while the control FSM waits)
//   i_addr       fetch byte address, bits [1:0] ignored
//   o_instr      instruction word, meaningful when i_start & ~o_stall
//   o_stall      instruction stall, combinational from i_start
//   mem          refill bus (instr_cache_if.master)
//   o_dbg_state  current refill FSM state
//   i_flush      invalidate all lines (only when ICACHE_FLUSH_EN is defined)
// Optional feature macro: ICACHE_FLUSH_EN.
module instr_cache
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int SET_COUNT   = 16,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [31:0]           o_instr,
  output logic                  o_stall,
`ifdef ICACHE_FLUSH_EN
  input  logic                  i_flush,
`endif
  instr_cache_if.master         mem,
  output t_icache_state         o_dbg_state
);
  localparam int OFF = off_width(BLOCK_WORDS);
  localparam int IDX = idx_width(SET_COUNT);
  localparam int TAG = tag_width(ADDR_WIDTH, SET_COUNT, BLOCK_WORDS);

  t_icache_state         state_q, state_d;
  logic [SET_COUNT-1:0]  valid_q, valid_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

  logic [TAG-1:0] tag_mem  [SET_COUNT];
  logic [31:0]    data_mem [SET_COUNT][BLOCK_WORDS];

  logic [OFF-1:0] off;
  logic [IDX-1:0] idx, lidx;
  logic [TAG-1:0] tag, ltag;
  logic           hit, ctr_clear, ctr_inc, ctr_last, install;
  logic [OFF-1:0] ctr_count;
  logic           flush_now;

  assign off  = i_addr[2 +: OFF];
  assign idx  = i_addr[OFF+2 +: IDX];
  assign tag  = i_addr[ADDR_WIDTH-1 -: TAG];
  // The refill writes only ever use the latched address.
  assign lidx = mem_addr_q[OFF+2 +: IDX];
  assign ltag = mem_addr_q[ADDR_WIDTH-1 -: TAG];

  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[1:0];

  assign hit = valid_q[idx] & (tag_mem[idx] == tag);

`ifdef ICACHE_FLUSH_EN
  // A flush seen outside IDLE is held until the FSM is back in IDLE, so the
  // line installed by that refill is also dropped.
  logic flush_pend_q, flush_pend_d;
  assign flush_now = (state_q == IDLE) & (i_flush | flush_pend_q);
`else
  assign flush_now = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ctr_clear  = 1'b0;
    ctr_inc    = 1'b0;
    install    = 1'b0;
`ifdef ICACHE_FLUSH_EN
    flush_pend_d = flush_pend_q;
    if (state_q != IDLE && i_flush) flush_pend_d = 1'b1;
`endif
    case (state_q)
      IDLE: begin
        if (flush_now) begin
          valid_d = '0;
`ifdef ICACHE_FLUSH_EN
          flush_pend_d = 1'b0;
`endif
        end else if (i_start && !hit) begin
          mem_addr_d   = {i_addr[ADDR_WIDTH-1:OFF+2], {(OFF+2){1'b0}}};
          ctr_clear    = 1'b1;
          valid_d[idx] = 1'b0;   // a half-written line must never hit
          mem_req_d    = 1'b1;
          state_d      = REFILL;
        end
      end
      REFILL: begin
        if (mem.i_mem_valid) begin
          ctr_inc = 1'b1;
          if (ctr_last) begin
            install       = 1'b1;
            valid_d[lidx] = 1'b1;
            mem_req_d     = 1'b0;
            state_d       = DONE;
          end
        end
      end
      // DONE gives the memory side one idle cycle before the re-lookup.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
`ifdef ICACHE_FLUSH_EN
      flush_pend_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
`ifdef ICACHE_FLUSH_EN
      flush_pend_q <= flush_pend_d;
`endif
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (state_q == REFILL && mem.i_mem_valid) data_mem[lidx][ctr_count] <= mem.i_mem_data;
    if (install) tag_mem[lidx] <= ltag;
  end

  icache_refill_ctr #(.BLOCK_WORDS(BLOCK_WORDS)) u_ctr (
    .clk   (clk),
    .rst   (arst),
    .clear (ctr_clear),
    .inc   (ctr_inc),
    .count (ctr_count),
    .last  (ctr_last)
  );

  assign o_stall     = i_start & (~((state_q == IDLE) & hit) | flush_now);
  // Gated with hit so the output is a clean 0 after reset and off-IDLE.
  assign o_instr     = ((state_q == IDLE) && hit) ? data_mem[idx][off] : 32'h0;
  assign mem.o_mem_req  = mem_req_q;
  assign mem.o_mem_addr = mem_addr_q;
  assign o_dbg_state = state_q;
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: randomized and directed checks of instr_cache against a
// line-level reference model (valid/tag/data arrays indexed by address arithmetic).
module tb_instr_cache;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic        i_start = 1'b0;
  logic [63:0] i_addr = '0;
  logic        i_mem_valid = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [31:0] o_instr;
  logic        o_stall;
  t_icache_state o_dbg_state;
`ifdef ICACHE_FLUSH_EN
  logic        i_flush = 1'b0;
`endif

  instr_cache_if #(.ADDR_WIDTH(64)) mem_if ();
  assign mem_if.i_mem_valid = i_mem_valid;
  assign mem_if.i_mem_data  = i_mem_data;

  instr_cache #(.ADDR_WIDTH(64), .SET_COUNT(16), .BLOCK_WORDS(16)) dut (
    .clk         (clk),
    .arst        (arst),
    .i_start     (i_start),
    .i_addr      (i_addr),
    .o_instr     (o_instr),
    .o_stall     (o_stall),
`ifdef ICACHE_FLUSH_EN
    .i_flush     (i_flush),
`endif
    .mem         (mem_if.master),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  bit          m_valid [16];
  logic [63:0] m_tag   [16];
  logic [31:0] m_data  [16][16];
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_invalidate_all();
    for (int s = 0; s < 16; s++) m_valid[s] = 1'b0;
  endtask

  // ---------------- driver ----------------
  // gap_mode: 0 = back-to-back beats, 1 = alternate idle cycles, 2 = random idles
  // (mode 2 also scrambles i_addr and i_start while the refill runs).
  task automatic fetch(input logic [63:0] addr, input int gap_mode,
                       input bit use_pat, input logic [31:0] pat);
    int          idx, off;
    logic [63:0] tag;
    bit          hit;
    logic [31:0] words [16];
    idx = int'((addr >> 6) % 64'd16);
    off = int'((addr >> 2) % 64'd16);
    tag = addr >> 10;
    hit = m_valid[idx] && (m_tag[idx] == tag);

    @(posedge clk); #1;
    i_start     = 1'b1;
    i_addr      = addr;
    i_mem_valid = 1'($urandom_range(0, 1));   // must be ignored in IDLE
    i_mem_data  = $urandom;
    #1;
    check("lookup_stall", o_stall, {63'd0, !hit});
    if (hit) begin
      exp_q.push_back(m_data[idx][off]);
      check("hit_instr", o_instr, exp_q.pop_front());
    end else begin
      @(posedge clk); #1;
      i_mem_valid = 1'b0;
      check("refill_req", mem_if.o_mem_req, 64'd1);
      check("refill_addr", mem_if.o_mem_addr, addr & ~64'h3F);
      for (int k = 0; k < 16; k++) begin
        words[k] = use_pat ? pat + 32'(k) : $urandom;
        if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
          i_mem_valid = 1'b0;
          i_mem_data  = $urandom;
          if (gap_mode == 2) begin
            i_addr  = {$urandom, $urandom};
            i_start = 1'($urandom_range(0, 1));
          end
          #1;
          check("gap_req", mem_if.o_mem_req, 64'd1);
          check("gap_stall", o_stall, {63'd0, i_start});
          @(posedge clk); #1;
        end
        i_mem_valid = 1'b1;
        i_mem_data  = words[k];
        if (gap_mode == 2) begin
          i_addr  = {$urandom, $urandom};
          i_start = 1'($urandom_range(0, 1));
        end
        #1;
        check("beat_stall", o_stall, {63'd0, i_start});
        @(posedge clk); #1;
      end
      // DONE cycle: memory side idle, fetch still stalled.
      i_mem_valid = 1'($urandom_range(0, 1));
      i_mem_data  = $urandom;
      i_start     = 1'b1;
      i_addr      = addr;
      #1;
      check("done_req", mem_if.o_mem_req, 64'd0);
      check("done_stall", o_stall, 64'd1);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      for (int k = 0; k < 16; k++) m_data[idx][k] = words[k];
      @(posedge clk); #1;
      i_mem_valid = 1'b0;
      #1;
      check("refill_hit_stall", o_stall, 64'd0);
      exp_q.push_back(m_data[idx][off]);
      check("refill_hit_instr", o_instr, exp_q.pop_front());
    end
    i_start     = 1'b0;
    i_mem_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_invalidate_all();
    #12;
    check("rst_req", mem_if.o_mem_req, 64'd0);
    check("rst_addr", mem_if.o_mem_addr, 64'd0);
    check("rst_stall", o_stall, 64'd0);
    check("rst_instr", o_instr, 64'd0);
    check("rst_state", 64'(o_dbg_state), 64'd0);
    #1 arst = 1'b0;

    // Cold fetch, hits across the whole line.
    fetch(64'h1000, 0, 1'b1, 32'hA0);
    fetch(64'h103C, 0, 1'b0, 32'h0);
    for (int a = 'h1004; a <= 'h1038; a += 4) fetch(64'(a), 0, 1'b0, 32'h0);

    // Conflict on index 0.
    fetch(64'h1400, 0, 1'b1, 32'hB0);
    fetch(64'h1000, 0, 1'b1, 32'hA0);
    fetch(64'h1420, 0, 1'b0, 32'h0);

    // Gapped beats.
    fetch(64'h2040, 1, 1'b1, 32'hC0);
    fetch(64'h207C, 0, 1'b0, 32'h0);

    // Reset in the middle of a refill of 0x2000 (index 0).
    @(posedge clk); #1;
    i_start = 1'b1;
    i_addr  = 64'h2000;
    @(posedge clk); #1;
    i_mem_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_mem_data = 32'hD0 + 32'(k);
      @(posedge clk); #1;
    end
    arst = 1'b1;
    #1;
    check("midrst_req", mem_if.o_mem_req, 64'd0);
    check("midrst_state", 64'(o_dbg_state), 64'd0);
    model_invalidate_all();
    i_start     = 1'b0;
    i_mem_valid = 1'b0;
    #1 arst = 1'b0;
    fetch(64'h1000, 0, 1'b1, 32'hA0);

    // Randomized traffic over a few tags so lines conflict and hit.
    for (int n = 0; n < 150; n++) begin
      logic [63:0] ra;
      ra = (64'($urandom_range(0, 3)) << 10) | (64'($urandom_range(0, 15)) << 6) |
           (64'($urandom_range(0, 15)) << 2) | 64'($urandom_range(0, 3));
      fetch(ra, $urandom_range(0, 2), 1'b0, 32'h0);
    end

`ifdef ICACHE_FLUSH_EN
    fetch(64'h1000, 0, 1'b1, 32'hA0);
    fetch(64'h1000, 0, 1'b0, 32'h0);
    @(posedge clk); #1;
    i_flush = 1'b1;
    i_start = 1'b1;
    i_addr  = 64'h1000;
    #1;
    check("flush_stall", o_stall, 64'd1);
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_start = 1'b0;
    model_invalidate_all();
    fetch(64'h1000, 0, 1'b1, 32'hE0);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
